// File: rtl/decode_stage_param.sv
// decode_stage_param
// IF/ID pipeline register, integer register file and RV immediate generator.
// Generic in data width and register count. Reads are combinational with an
// optional write-first bypass from the writeback stage. Index 0 is hard-wired
// to zero. Any index at or above NUM_REGS reads as zero, and writes to such
// an index are dropped.

module decode_stage_param #(
  parameter int          XLEN         = 32,
  parameter int          NUM_REGS     = 32,
  parameter bit          WRITE_BYPASS = 1'b1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_fetch,
  input  logic [XLEN-1:0] pc_plus4_fetch,
  input  logic [31:0]     instruction_fetch,
  input  logic            valid_fetch,
  input  logic            flush_decode,
  input  logic            stall_decode,
  input  logic [2:0]      imm_src_decode,
  input  logic            reg_write_enable_writeback,
  input  logic [4:0]      write_register_writeback,
  input  logic [XLEN-1:0] write_data_writeback,
  output logic [31:0]     instruction_decode,
  output logic [XLEN-1:0] pc_decode,
  output logic [XLEN-1:0] pc_plus4_decode,
  output logic            valid_decode,
  output logic [4:0]      rs1_decode,
  output logic [4:0]      rs2_decode,
  output logic [4:0]      rd_decode,
  output logic [XLEN-1:0] read_data1_decode,
  output logic [XLEN-1:0] read_data2_decode,
  output logic [XLEN-1:0] immediate_extended_decode
);

  // Storage is indexed with only as many bits as the register count needs.
  // The 5-bit architectural index is range-checked before it is narrowed.
  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcPlus4;
  logic            r_valid;
  logic [XLEN-1:0] r_regs [NUM_REGS];

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_rs1InRange;
  logic            w_rs2InRange;
  logic            w_writeInRange;
  logic            w_writeEn;
  logic [IDX_W-1:0] w_writeIdx;
  logic [XLEN-1:0] w_readData1;
  logic [XLEN-1:0] w_readData2;
  logic [31:0]     w_imm32;

  // Decode register: reset and flush both insert a NOP bubble; flush beats stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pcPlus4 <= '0;
      r_valid   <= 1'b0;
    end else if (flush_decode) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pcPlus4 <= '0;
      r_valid   <= 1'b0;
    end else if (!stall_decode) begin
      r_instr   <= instruction_fetch;
      r_pc      <= pc_fetch;
      r_pcPlus4 <= pc_plus4_fetch;
      r_valid   <= valid_fetch;
    end
  end

  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_rd  = r_instr[11:7];

  assign w_rs1InRange   = ({1'b0, w_rs1} < NUM_REGS_W);
  assign w_rs2InRange   = ({1'b0, w_rs2} < NUM_REGS_W);
  assign w_writeInRange = ({1'b0, write_register_writeback} < NUM_REGS_W);

  // Writes go through regardless of stall or flush; x0 and out-of-range
  // indices never commit.
  assign w_writeEn  = reg_write_enable_writeback &&
                      (write_register_writeback != 5'd0) && w_writeInRange;
  assign w_writeIdx = write_register_writeback[IDX_W-1:0];

  // Register file storage, fully cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[w_writeIdx] <= write_data_writeback;
    end
  end

  // Combinational read ports. A committing writeback to the same register
  // overrides the stored value when the bypass is enabled.
  always_comb begin
    w_readData1 = '0;
    w_readData2 = '0;
    if ((w_rs1 != 5'd0) && w_rs1InRange) begin
      w_readData1 = r_regs[w_rs1[IDX_W-1:0]];
    end
    if ((w_rs2 != 5'd0) && w_rs2InRange) begin
      w_readData2 = r_regs[w_rs2[IDX_W-1:0]];
    end
    if (WRITE_BYPASS && w_writeEn && (write_register_writeback == w_rs1)) begin
      w_readData1 = write_data_writeback;
    end
    if (WRITE_BYPASS && w_writeEn && (write_register_writeback == w_rs2)) begin
      w_readData2 = write_data_writeback;
    end
  end

  // Immediate assembly at 32 bits. Every format takes its sign from bit 31,
  // so widening to XLEN afterwards is a single replication.
  always_comb begin
    w_imm32 = '0;
    case (imm_src_decode)
      IMM_I:   w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
      IMM_S:   w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      IMM_B:   w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                          r_instr[30:25], r_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {r_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                          r_instr[20], r_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  if (XLEN > 32) begin : g_immWide
    assign immediate_extended_decode = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end else begin : g_immNarrow
    assign immediate_extended_decode = w_imm32[XLEN-1:0];
  end

  assign instruction_decode = r_instr;
  assign pc_decode          = r_pc;
  assign pc_plus4_decode    = r_pcPlus4;
  assign valid_decode       = r_valid;
  assign rs1_decode         = w_rs1;
  assign rs2_decode         = w_rs2;
  assign rd_decode          = w_rd;
  assign read_data1_decode  = w_readData1;
  assign read_data2_decode  = w_readData2;

endmodule

// File: tb/tb_decode_stage_param.sv
// tb_decode_stage_param
// Two instances share one stimulus stream. Instance A uses the default
// configuration (32-bit, 32 registers, bypass on). Instance B is 64-bit with
// 16 registers and the bypass off. Each cycle the stimulus pushes the
// expected outputs of both instances into a queue. A monitor on the falling
// edge pops that entry and compares it with the outputs.

module tb_decode_stage_param;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rstn;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        vf;
    logic        flush;
    logic        stall;
    logic [2:0]  immSrc;
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
  } stimT;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic        valid;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] aImm;
    logic [63:0] b1;
    logic [63:0] b2;
    logic [63:0] bImm;
  } expT;

  logic        clk;
  logic        reset_n;
  logic [63:0] pcFetch;
  logic [63:0] pc4Fetch;
  logic [31:0] instrFetch;
  logic        validFetch;
  logic        flushDecode;
  logic        stallDecode;
  logic [2:0]  immSrc;
  logic        weWb;
  logic [4:0]  wrWb;
  logic [63:0] wdWb;

  logic [31:0] aInstr, aPc, aPc4, aRd1, aRd2, aImm;
  logic        aValid;
  logic [4:0]  aRs1, aRs2, aRd;
  logic [31:0] bInstr;
  logic [63:0] bPc, bPc4, bRd1, bRd2, bImm;
  logic        bValid;
  logic [4:0]  bRs1, bRs2, bRd;

  expT         sb[$];
  expT         mon;
  int          nTests = 0;
  int          nFail = 0;
  int          cycleNo = 0;

  logic [31:0] mInstr;
  logic [63:0] mPc;
  logic [63:0] mPc4;
  logic        mValid;
  logic [31:0] regA [32];
  logic [63:0] regB [16];

  decode_stage_param dutA (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .pc_fetch                   (pcFetch[31:0]),
    .pc_plus4_fetch             (pc4Fetch[31:0]),
    .instruction_fetch          (instrFetch),
    .valid_fetch                (validFetch),
    .flush_decode               (flushDecode),
    .stall_decode               (stallDecode),
    .imm_src_decode             (immSrc),
    .reg_write_enable_writeback (weWb),
    .write_register_writeback   (wrWb),
    .write_data_writeback       (wdWb[31:0]),
    .instruction_decode         (aInstr),
    .pc_decode                  (aPc),
    .pc_plus4_decode            (aPc4),
    .valid_decode               (aValid),
    .rs1_decode                 (aRs1),
    .rs2_decode                 (aRs2),
    .rd_decode                  (aRd),
    .read_data1_decode          (aRd1),
    .read_data2_decode          (aRd2),
    .immediate_extended_decode  (aImm)
  );

  decode_stage_param #(
    .XLEN         (64),
    .NUM_REGS     (16),
    .WRITE_BYPASS (1'b0)
  ) dutB (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .pc_fetch                   (pcFetch),
    .pc_plus4_fetch             (pc4Fetch),
    .instruction_fetch          (instrFetch),
    .valid_fetch                (validFetch),
    .flush_decode               (flushDecode),
    .stall_decode               (stallDecode),
    .imm_src_decode             (immSrc),
    .reg_write_enable_writeback (weWb),
    .write_register_writeback   (wrWb),
    .write_data_writeback       (wdWb),
    .instruction_decode         (bInstr),
    .pc_decode                  (bPc),
    .pc_plus4_decode            (bPc4),
    .valid_decode               (bValid),
    .rs1_decode                 (bRs1),
    .rs2_decode                 (bRs2),
    .rd_decode                  (bRd),
    .read_data1_decode          (bRd1),
    .read_data2_decode          (bRd2),
    .immediate_extended_decode  (bImm)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Immediate value: each format's bits are weighted by their place value,
  // and the result is made negative by subtracting 2^width when bit 31 is set.
  function automatic logic [63:0] immModel(input logic [31:0] ins, input logic [2:0] src);
    longint v;
    int     w;
    v = 0;
    w = 0;
    case (src)
      3'd0: begin v = longint'(ins[31:20]); w = 12; end
      3'd1: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); w = 12; end
      3'd2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        w = 13;
      end
      3'd3: begin v = longint'(ins[31:12]) * 4096; w = 32; end
      3'd4: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        w = 21;
      end
      default: begin v = 0; w = 0; end
    endcase
    if ((w != 0) && ins[31]) v = v - (longint'(1) << w);
    return 64'(v);
  endfunction

  function automatic logic [31:0] readA(input logic [4:0] idx, input stimT s);
    if (idx == 5'd0) return 32'd0;
    if (s.we && (s.wr == idx)) return s.wd[31:0];
    return regA[idx];
  endfunction

  function automatic logic [63:0] readB(input logic [4:0] idx);
    if ((idx == 5'd0) || (idx >= 5'd16)) return 64'd0;
    return regB[idx[3:0]];
  endfunction

  function automatic stimT idle();
    stimT s;
    s.rstn = 1'b1; s.pc = '0; s.instr = NOP; s.vf = 1'b0;
    s.flush = 1'b0; s.stall = 1'b0; s.immSrc = 3'd0;
    s.we = 1'b0; s.wr = 5'd0; s.wd = '0;
    return s;
  endfunction

  task automatic clearModel();
    mInstr = NOP; mPc = '0; mPc4 = '0; mValid = 1'b0;
    for (int i = 0; i < 32; i++) regA[i] = '0;
    for (int i = 0; i < 16; i++) regB[i] = '0;
  endtask

  // Drive one cycle, queue what both instances must show during that cycle,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input stimT s);
    expT e;
    reset_n = s.rstn; pcFetch = s.pc; pc4Fetch = s.pc + 64'd4;
    instrFetch = s.instr; validFetch = s.vf; flushDecode = s.flush;
    stallDecode = s.stall; immSrc = s.immSrc; weWb = s.we; wrWb = s.wr; wdWb = s.wd;
    if (!s.rstn) clearModel();
    e.cyc = cycleNo; e.instr = mInstr; e.pc = mPc; e.pc4 = mPc4; e.valid = mValid;
    e.a1 = readA(mInstr[19:15], s);
    e.a2 = readA(mInstr[24:20], s);
    e.b1 = readB(mInstr[19:15]);
    e.b2 = readB(mInstr[24:20]);
    e.bImm = immModel(mInstr, s.immSrc);
    e.aImm = e.bImm[31:0];
    sb.push_back(e);
    cycleNo++;
    @(posedge clk);
    if (s.rstn) begin
      if (s.we && (s.wr != 5'd0)) begin
        regA[s.wr] = s.wd[31:0];
        if (s.wr < 5'd16) regB[s.wr[3:0]] = s.wd;
      end
      if (s.flush) begin
        mInstr = NOP; mPc = '0; mPc4 = '0; mValid = 1'b0;
      end else if (!s.stall) begin
        mInstr = s.instr; mPc = s.pc; mPc4 = s.pc + 64'd4; mValid = s.vf;
      end
    end
    #1;
  endtask

  task automatic checkOutput(input int cyc, input string name,
                             input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL cycle %0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      checkOutput(mon.cyc, "a_instr", 64'(aInstr), 64'(mon.instr));
      checkOutput(mon.cyc, "a_pc",    64'(aPc),    64'(mon.pc[31:0]));
      checkOutput(mon.cyc, "a_pc4",   64'(aPc4),   64'(mon.pc4[31:0]));
      checkOutput(mon.cyc, "a_valid", 64'(aValid), 64'(mon.valid));
      checkOutput(mon.cyc, "a_rs1",   64'(aRs1),   64'(mon.instr[19:15]));
      checkOutput(mon.cyc, "a_rs2",   64'(aRs2),   64'(mon.instr[24:20]));
      checkOutput(mon.cyc, "a_rd",    64'(aRd),    64'(mon.instr[11:7]));
      checkOutput(mon.cyc, "a_rd1",   64'(aRd1),   64'(mon.a1));
      checkOutput(mon.cyc, "a_rd2",   64'(aRd2),   64'(mon.a2));
      checkOutput(mon.cyc, "a_imm",   64'(aImm),   64'(mon.aImm));
      checkOutput(mon.cyc, "b_instr", 64'(bInstr), 64'(mon.instr));
      checkOutput(mon.cyc, "b_pc",    bPc,         mon.pc);
      checkOutput(mon.cyc, "b_pc4",   bPc4,        mon.pc4);
      checkOutput(mon.cyc, "b_valid", 64'(bValid), 64'(mon.valid));
      checkOutput(mon.cyc, "b_rs1",   64'(bRs1),   64'(mon.instr[19:15]));
      checkOutput(mon.cyc, "b_rd",    64'(bRd),    64'(mon.instr[11:7]));
      checkOutput(mon.cyc, "b_rd1",   bRd1,        mon.b1);
      checkOutput(mon.cyc, "b_rd2",   bRd2,        mon.b2);
      checkOutput(mon.cyc, "b_imm",   bImm,        mon.bImm);
    end
  end

  initial begin
    stimT s;
    logic [31:0] immInstr [4];
    logic [2:0]  immCode  [4];
    immInstr[0] = 32'hFE000EE3; immCode[0] = 3'd2;
    immInstr[1] = 32'h800000EF; immCode[1] = 3'd4;
    immInstr[2] = 32'hABCDE037; immCode[2] = 3'd3;
    immInstr[3] = 32'hABCDE037; immCode[3] = 3'd7;

    reset_n = 1'b0; pcFetch = '0; pc4Fetch = '0; instrFetch = '0; validFetch = 1'b0;
    flushDecode = 1'b0; stallDecode = 1'b0; immSrc = '0; weWb = 1'b0; wrWb = '0; wdWb = '0;
    clearModel();
    @(posedge clk);
    #1;

    // Reset state, then a write to x5 that commits.
    s = idle(); s.rstn = 1'b0; s.instr = $urandom; s.we = 1'b1; s.wr = 5'd5; s.wd = 64'h99;
    applyStimulus(s);
    s = idle(); s.instr = 32'h0002_8313; s.pc = 64'h80; s.vf = 1'b1;
    s.we = 1'b1; s.wr = 5'd5; s.wd = 64'h55;
    applyStimulus(s);
    s = idle(); s.instr = 32'h00A0_0293; s.pc = 64'h100; s.vf = 1'b1;
    applyStimulus(s);
    // Reset falls mid-cycle during a stall with a write pending; the write is lost.
    s = idle(); s.rstn = 1'b0; s.stall = 1'b1; s.instr = $urandom;
    s.we = 1'b1; s.wr = 5'd5; s.wd = 64'h77;
    applyStimulus(s);
    s = idle(); s.instr = 32'h0002_8313; s.pc = 64'h40; s.vf = 1'b1;
    applyStimulus(s);
    // Load addi x5,x0,10 at 0x100, then hold it through three stalls.
    s = idle(); s.instr = 32'h00A0_0293; s.pc = 64'h100; s.vf = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.instr = $urandom; s.pc = 64'h200 + 64'(i * 4); s.vf = 1'b1;
      applyStimulus(s);
    end
    // Flush together with stall inserts a bubble.
    s = idle(); s.flush = 1'b1; s.stall = 1'b1; s.instr = $urandom; s.vf = 1'b1;
    applyStimulus(s);
    // Same-cycle bypass on rs1 = x7.
    s = idle(); s.instr = 32'h0003_8393; s.pc = 64'h300; s.vf = 1'b1;
    applyStimulus(s);
    s = idle(); s.stall = 1'b1; s.we = 1'b1; s.wr = 5'd7; s.wd = 64'hDEAD_BEEF;
    applyStimulus(s);
    s = idle(); s.stall = 1'b1;
    applyStimulus(s);
    // x0 write never lands or forwards.
    s = idle(); s.flush = 1'b1;
    applyStimulus(s);
    s = idle(); s.stall = 1'b1; s.we = 1'b1; s.wr = 5'd0; s.wd = '1;
    applyStimulus(s);
    // x20 is beyond the 16-entry file of instance B.
    s = idle(); s.instr = 32'h000A_0013; s.vf = 1'b1;
    applyStimulus(s);
    s = idle(); s.stall = 1'b1; s.we = 1'b1; s.wr = 5'd20; s.wd = 64'h1234_5678;
    applyStimulus(s);
    s = idle(); s.stall = 1'b1;
    applyStimulus(s);
    // Immediate corner cases: load the word, then select the format while held.
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.instr = immInstr[i]; s.vf = 1'b1;
      applyStimulus(s);
      s = idle(); s.stall = 1'b1; s.immSrc = immCode[i];
      applyStimulus(s);
    end

    // Randomized traffic, with writeback often aimed at a live source register.
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rstn   = ($urandom_range(0, 99) != 0);
      s.pc     = {$urandom, $urandom};
      s.instr  = $urandom;
      s.vf     = 1'($urandom_range(0, 1));
      s.flush  = ($urandom_range(0, 9) == 0);
      s.stall  = ($urandom_range(0, 4) == 0);
      s.immSrc = 3'($urandom_range(0, 7));
      s.we     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       s.wr = mInstr[19:15];
        1:       s.wr = mInstr[24:20];
        default: s.wr = 5'($urandom_range(0, 31));
      endcase
      s.wd = {$urandom, $urandom};
      applyStimulus(s);
    end

    @(negedge clk);
    #1;
    checkOutput(-1, "sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised IF/ID decode stage for the pipelined core: the fetch-to-decode pipeline register with a valid bit, the integer register file, and full RV immediate generation (I/S/B/U/J). It is generic in data width and register count and adds write-first bypass, an x0 hard-zero, and decoded register-index outputs for the hazard unit. It sits between the fetch unit and the ID/EX register, and takes writeback from the W stage.

## Interface
Parameters:
- XLEN, 32, data and PC width (32 or 64).
- NUM_REGS, 32, architectural register count (32, or 16 for RV32E). Index width is log2(NUM_REGS).
- WRITE_BYPASS, 1: when 1, a same-cycle writeback to a read register is forwarded to the read data.
- NOP_INSTR, 32'h0000_0013, instruction value loaded on reset and on flush (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset. One clock domain only.
- pc_fetch  in  XLEN  PC of the fetched instruction.
- pc_plus4_fetch  in  XLEN  fetched PC + 4.
- instruction_fetch  in  32  fetched instruction.
- valid_fetch  in  1  fetch output is a real instruction.
- flush_decode  in  1  squash the decode register.
- stall_decode  in  1  hold the decode register.
- imm_src_decode  in  3  000 I, 001 S, 010 B, 011 U, 100 J; all other codes give immediate 0.
- reg_write_enable_writeback  in  1  writeback enable.
- write_register_writeback  in  5  writeback destination.
- write_data_writeback  in  XLEN  writeback data.
- instruction_decode  out  32  registered instruction.
- pc_decode  out  XLEN  registered PC.
- pc_plus4_decode  out  XLEN  registered PC + 4.
- valid_decode  out  1  decode slot holds a live instruction.
- rs1_decode, rs2_decode, rd_decode  out  5 each  fields [19:15], [24:20], [11:7] of instruction_decode.
- read_data1_decode, read_data2_decode  out  XLEN  register operands.
- immediate_extended_decode  out  XLEN  sign-extended immediate.

## Operation
- Decode register update priority at each rising edge:
  1. reset_n low: instruction = NOP_INSTR, PC = 0, PC+4 = 0, valid = 0.
  2. flush_decode: same values as reset.
  3. stall_decode: all decode register fields hold.
  4. Otherwise: load the fetch inputs; valid_decode = valid_fetch.
- When flush and stall are both asserted, flush wins.
- Register file:
  - NUM_REGS entries of XLEN bits, all cleared asynchronously on reset.
  - A write occurs on the rising edge when enable is 1, the index is not 0, and the index is less than NUM_REGS. All other writes are ignored.
  - Reads are combinational.
  - Index 0, or any index ≥ NUM_REGS, reads 0.
- Bypass (WRITE_BYPASS=1): if enable is 1, write_register is not 0, and write_register equals rs, the read returns write_data_writeback in the same cycle. With WRITE_BYPASS=0 the read returns the stored value; the new value appears after the edge.
- Writes proceed regardless of stall or flush.
- Immediates, all sign-extended from bit 31 to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- rs1/rs2/rd and the immediate are derived from instruction_decode every cycle, whether or not valid_decode is set.

## Timing
- Latency is one cycle from fetch inputs to the decode register. Read data and immediate are combinational from the decode register and regfile state, plus the writeback inputs when bypass is enabled.
- Reset is asynchronous: outputs clear immediately when reset_n falls, with no clock needed. This includes mid-stall and a write in the same cycle; the write is lost.
- Outputs stay at reset values until the first rising edge after reset_n rises.
- A stall holds the register for any number of cycles, and the held instruction's read data tracks regfile writes during the stall.
- A flush takes effect on the edge at which it is sampled. The instruction presented on that edge is discarded.
- After reset, every output is 0 except instruction_decode, which is NOP_INSTR. The immediate for NOP_INSTR with imm_src 000 is 0.

## Test plan
- Reset: drive reset_n low mid-cycle -> outputs clear without a clock edge; instruction_decode = 0x00000013, valid_decode = 0, and x5 reads 0 after release.
- Load/stall/flush: fetch 0x00A00293 at PC 0x100 -> next cycle pc_decode = 0x100, pc_plus4 = 0x104, valid = 1, rd = 5, I-immediate = 10. Assert stall for 3 cycles with new fetch data -> all outputs unchanged. Assert flush and stall together -> NOP, valid = 0.
- Bypass: decode holds rs1 = 7; write x7 = 0xDEADBEEF in the same cycle -> read_data1 = 0xDEADBEEF that cycle with WRITE_BYPASS=1. With WRITE_BYPASS=0 it reads the old value, then 0xDEADBEEF after the edge.
- x0 and range: write x0 = 0xFFFFFFFF -> x0 reads 0 and the bypass does not fire. With NUM_REGS=16, write x20 -> ignored, and reading x20 returns 0.
- Immediates, checked at XLEN 32 and XLEN 64 sign extension:
  - 0xFE000EE3 with B -> −4.
  - 0x800000EF with J -> 0xFFF00000 (32-bit), i.e. −1048576.
  - 0xABCDE037 with U -> 0xABCDE000 (64-bit: 0xFFFFFFFFABCDE000).
  - Code 111 -> 0.
